// File: rtl/sync_capture_controller.sv
// Capture controller for a wide two-flop synchronizer: flushes the
// synchronizer, waits for a stable bus value and hands it off with valid/ready.
module sync_capture_controller #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 2,
    parameter int TIMEOUT       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             sync_enable,
    input  logic [WIDTH-1:0] sync_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] LIMIT_C  = CW'(TIMEOUT);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WARMUP  = 2'd1;
    localparam logic [1:0] COMPARE = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    logic [1:0]       state;
    logic             warm;
    logic [WIDTH-1:0] sample;
    logic [CW-1:0]    match;
    logic [CW-1:0]    cycles;

    logic          first;
    logic [CW-1:0] match_nx;
    logic [CW-1:0] cycles_nx;
    logic          accept;
    logic          expire;

    // cycles==0 marks the first COMPARE cycle since it is cleared on entry
    always_comb begin
        first     = (cycles == '0);
        match_nx  = (first || sync_data != sample) ? ONE : match + ONE;
        cycles_nx = cycles + ONE;
        accept    = (match_nx == STABLE_C);
        expire    = (cycles_nx == LIMIT_C);
    end

    assign sync_enable = (state == WARMUP) || (state == COMPARE);
    assign out_valid   = (state == HOLD);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            warm        <= 1'b0;
            sample      <= '0;
            match       <= '0;
            cycles      <= '0;
            out_data    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WARMUP;
                        warm  <= 1'b0;
                    end
                end
                WARMUP: begin
                    warm <= 1'b1;
                    if (warm) begin
                        state  <= COMPARE;
                        match  <= '0;
                        cycles <= '0;
                    end
                end
                COMPARE: begin
                    sample <= sync_data;
                    match  <= match_nx;
                    cycles <= cycles_nx;
                    // acceptance wins over a simultaneous timeout
                    if (accept) begin
                        state    <= HOLD;
                        out_data <= sync_data;
                    end else if (expire) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sync_capture_controller.md
SYNC_CAPTURE_CONTROLLER -- requirements
Module: sync_capture_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data bus width in bits.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 2, giving the number of consecutive identical samples needed to accept a value; legal range 1..TIMEOUT.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of cycles spent in COMPARE before abandoning a capture; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: a capture request, sampled in IDLE only.
REQ-007 The block SHALL have port sync_enable, output, 1 bit: the enable driven to the wide two-flop synchronizer.
REQ-008 The block SHALL have port sync_data, input, WIDTH bits: the synchronizer output bus.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: the last accepted value.
REQ-010 The block SHALL have port out_valid, output, 1 bit: an accepted value is pending.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-012 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: a one-cycle pulse on an abandoned capture.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, WARMUP, COMPARE and HOLD; all outputs SHALL be registered or decoded from the state register.
REQ-015 In IDLE, a cycle with start=1 SHALL move the FSM to WARMUP; start=0 SHALL keep it in IDLE.
REQ-016 WARMUP SHALL last exactly 2 cycles (the synchronizer flush), then move to COMPARE.
REQ-017 sync_enable SHALL be 1 in WARMUP and COMPARE, and 0 in IDLE and HOLD.
REQ-018 In the first COMPARE cycle, the block SHALL load sync_data into a sample register and set the match count to 1.
REQ-019 In each later COMPARE cycle, if sync_data equals the sample register the match count SHALL increment; otherwise the sample register SHALL load sync_data and the count SHALL reset to 1.
REQ-020 In the cycle the match count reaches STABLE_CYCLES, the FSM SHALL move to HOLD, load out_data with the sample value, and set out_valid=1 from the next cycle.
REQ-021 From a constant bus, out_valid SHALL rise exactly 3+STABLE_CYCLES cycles after the start cycle (5 cycles at the defaults).
REQ-022 A COMPARE cycle counter SHALL count cycles spent in COMPARE; when it reaches TIMEOUT without acceptance, the FSM SHALL return to IDLE, pulse timeout_err for 1 cycle, and leave out_data unchanged.
REQ-023 If acceptance and timeout occur in the same cycle, acceptance SHALL win and no timeout_err SHALL be generated.
REQ-024 In HOLD, out_valid and out_data SHALL remain stable until the first cycle with out_ready=1; that cycle completes the handshake, and the FSM SHALL enter IDLE with out_valid=0 in the following cycle.
REQ-025 start SHALL be ignored outside IDLE; start held high SHALL begin a new capture in the cycle after IDLE is re-entered.
REQ-026 out_ready seen outside HOLD SHALL have no effect.
REQ-027 busy SHALL be 1 in WARMUP, COMPARE and HOLD.
REQ-028 Both counters SHALL be wide enough for TIMEOUT without wrap-around and SHALL clear on every entry to COMPARE.

Reset
REQ-029 While rst=0, the FSM SHALL be in IDLE and all of the following SHALL be 0: out_data, out_valid, sync_enable, busy, timeout_err, the sample register and both counters.
REQ-030 Asserting rst in any state, including mid-capture or in HOLD, SHALL abort immediately with no handshake or timeout_err pulse.
REQ-031 After rst is deasserted, the first capture SHALL begin only on a start seen in IDLE.

Verification
REQ-032 Scenario: sync_data=8'hA5 held constant, start pulsed at cycle 0 -> sync_enable=1 in cycles 1-4, out_valid=1 with out_data=8'hA5 from cycle 5, busy=1 in cycles 1-5.
REQ-033 Scenario: the bus toggles 8'h0F/8'hF0 every cycle, TIMEOUT=16 -> timeout_err pulses once 16 COMPARE cycles after entry, out_valid stays 0, and out_data keeps its prior value.
REQ-034 Scenario: in COMPARE the bus reads 8'h11, 8'h12, 8'h12 -> acceptance of 8'h12 on the third sample, with out_valid one cycle later.
REQ-035 Scenario: out_ready held 0 for 10 cycles in HOLD while sync_data and start change -> out_data and out_valid are unchanged and sync_enable=0; after out_ready=1 for 1 cycle, out_valid=0 next cycle.
REQ-036 Scenario: rst asserted during WARMUP and again during HOLD -> all outputs are 0 in the same cycle, and the next start yields normal 5-cycle latency.
REQ-037 Scenario: STABLE_CYCLES=TIMEOUT=4 with the bus stable from the third COMPARE sample -> acceptance does not occur in time, so timeout_err=1; with the bus stable from the first sample -> accepted, timeout_err=0 (tie rule of REQ-023).
